// File: rtl/barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings and level-to-stage mapping.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package barrel_shifter_pkg;

    localparam logic [1:0] BARREL_SHIFT_MODE_LSR = 2'b00;
    localparam logic [1:0] BARREL_SHIFT_MODE_LSL = 2'b01;
    localparam logic [1:0] BARREL_SHIFT_MODE_ASR = 2'b10;
    localparam logic [1:0] BARREL_SHIFT_MODE_ROR = 2'b11;

    // Number of mux levels handled by register stage idx. Levels are dealt out
    // LSB first, ceil(shift_width/stages) per stage, so trailing stages may get none.
    function automatic int stage_levels(input int shift_width, input int stages, input int idx);
        int per;
        int first;
        per   = (shift_width + stages - 1) / stages;
        first = idx * per;
        if (first >= shift_width) begin
            return 0;
        end
        return ((shift_width - first) < per) ? (shift_width - first) : per;
    endfunction

endpackage

// File: rtl/barrel_shifter_stage.sv
// Combinational slice of the barrel shifter: applies levels FIRST_LEVEL..FIRST_LEVEL+NUM_LEVELS-1.
// Latency: 0 cycles (pure combinational). Backpressure: none, the enclosing pipeline handles it.
// Ports: data_in/data_out operand, shift = full shift amount, mode/pad/sign = per-beat controls.
module barrel_shifter_stage
    import barrel_shifter_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SHIFT_WIDTH = 3,
    parameter int FIRST_LEVEL = 0,
    parameter int NUM_LEVELS  = 1
) (
    input  logic [WIDTH-1:0]       data_in,
    input  logic [SHIFT_WIDTH-1:0] shift,
    input  logic [1:0]             mode,
    input  logic                   pad,
    input  logic                   sign,
    output logic [WIDTH-1:0]       data_out
);

    localparam logic [WIDTH-1:0] ONES = '1;

    // Each slice only looks at its own shift bits; a zero-level slice looks at none.
    logic unused_inputs;
    assign unused_inputs = ^{shift, mode, pad, sign};

    logic [WIDTH-1:0] lvl [NUM_LEVELS+1];
    assign lvl[0] = data_in;

    for (genvar n = 0; n < NUM_LEVELS; n++) begin : g_level
        localparam int K     = FIRST_LEVEL + n;
        localparam int AMT   = 1 << K;
        // A shift of WIDTH or more clears everything to fill; clamp so the
        // shift operators never see an out-of-range amount.
        localparam int AMT_C = (AMT > WIDTH) ? WIDTH : AMT;
        localparam int ROT   = AMT % WIDTH;

        logic             fill;
        logic [WIDTH-1:0] rsh;
        logic [WIDTH-1:0] lsh;
        logic [WIDTH-1:0] rot;

        // ASR fills with the sign of the original operand, not of this level's input.
        assign fill = (mode == BARREL_SHIFT_MODE_ASR) ? sign : pad;
        assign rsh  = (lvl[n] >> AMT_C) | ({WIDTH{fill}} & ~(ONES >> AMT_C));
        assign lsh  = (lvl[n] << AMT_C) | ({WIDTH{pad}}  & ~(ONES << AMT_C));
        assign rot  = (lvl[n] >> ROT)   | (lvl[n] << (WIDTH - ROT));

        assign lvl[n+1] = !shift[K]                        ? lvl[n] :
                          (mode == BARREL_SHIFT_MODE_LSL) ? lsh    :
                          (mode == BARREL_SHIFT_MODE_ROR) ? rot    :
                                                            rsh;
    end

    assign data_out = lvl[NUM_LEVELS];

endmodule

// File: rtl/barrel_shifter_pipelined.sv
// Multi-mode (LSR/LSL/ASR/ROR) barrel shifter split over STAGES registered stages.
// Latency: STAGES cycles from acceptance to out_valid; one beat per cycle sustained.
// Backpressure: valid/ready with bubble collapsing; in_ready is combinational from out_ready.
// Ports: clock/resetn; in_valid/in_ready/in_data/in_shift/in_mode/in_pad; out_valid/out_ready/out_data.
module barrel_shifter_pipelined
    import barrel_shifter_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SHIFT_WIDTH = $clog2(WIDTH),
    parameter int STAGES      = SHIFT_WIDTH
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SHIFT_WIDTH-1:0] in_shift,
    input  logic [1:0]             in_mode,
    input  logic                   in_pad,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data
);

    localparam int LEVELS_PER_STAGE = (SHIFT_WIDTH + STAGES - 1) / STAGES;

    // Stage registers
    logic [STAGES-1:0]      v_q;
    logic [WIDTH-1:0]       d_q    [STAGES];
    logic [SHIFT_WIDTH-1:0] sh_q   [STAGES];
    logic [1:0]             mode_q [STAGES];
    logic [STAGES-1:0]      pad_q;
    logic [STAGES-1:0]      sign_q;

    // What each stage would load, and whether it loads this cycle
    logic [STAGES-1:0]      src_v;
    logic [STAGES-1:0]      src_pad;
    logic [STAGES-1:0]      src_sign;
    logic [WIDTH-1:0]       src_d    [STAGES];
    logic [SHIFT_WIDTH-1:0] src_sh   [STAGES];
    logic [1:0]             src_mode [STAGES];
    logic [WIDTH-1:0]       st_d     [STAGES];
    logic [STAGES-1:0]      adv;

    // A stage advances if it is empty or everything downstream of it can move.
    // Accumulated from the output end so there is no combinational self-loop.
    always_comb begin
        logic acc;
        acc = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            acc    = acc || !v_q[i];
            adv[i] = acc;
        end
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign src_v[i]    = in_valid;
            assign src_d[i]    = in_data;
            assign src_sh[i]   = in_shift;
            assign src_mode[i] = in_mode;
            assign src_pad[i]  = in_pad;
            assign src_sign[i] = in_data[WIDTH-1];
        end else begin : g_body
            assign src_v[i]    = v_q[i-1];
            assign src_d[i]    = d_q[i-1];
            assign src_sh[i]   = sh_q[i-1];
            assign src_mode[i] = mode_q[i-1];
            assign src_pad[i]  = pad_q[i-1];
            assign src_sign[i] = sign_q[i-1];
        end

        barrel_shifter_stage #(
            .WIDTH       (WIDTH),
            .SHIFT_WIDTH (SHIFT_WIDTH),
            .FIRST_LEVEL (i * LEVELS_PER_STAGE),
            .NUM_LEVELS  (stage_levels(SHIFT_WIDTH, STAGES, i))
        ) u_stage (
            .data_in  (src_d[i]),
            .shift    (src_sh[i]),
            .mode     (src_mode[i]),
            .pad      (src_pad[i]),
            .sign     (src_sign[i]),
            .data_out (st_d[i])
        );
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            v_q    <= '0;
            pad_q  <= '0;
            sign_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                d_q[i]    <= '0;
                sh_q[i]   <= '0;
                mode_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (adv[i]) begin
                    v_q[i]    <= src_v[i];
                    d_q[i]    <= st_d[i];
                    sh_q[i]   <= src_sh[i];
                    mode_q[i] <= src_mode[i];
                    pad_q[i]  <= src_pad[i];
                    sign_q[i] <= src_sign[i];
                end
            end
        end
    end

    // The last stage's control fields have no consumer.
    logic unused_tail;
    assign unused_tail = ^{sh_q[STAGES-1], mode_q[STAGES-1], pad_q[STAGES-1], sign_q[STAGES-1]};

    assign in_ready  = adv[0];
    assign out_valid = v_q[STAGES-1];
    // Stale data in an empty last stage is never exposed.
    assign out_data  = v_q[STAGES-1] ? d_q[STAGES-1] : '0;

endmodule

// File: tb/tb_barrel_shifter_pipelined.sv
module tb_barrel_shifter_pipelined;

    logic       clock  = 1'b0;
    logic       resetn = 1'b0;

    logic       in8_valid, in8_ready, out8_valid, out8_ready;
    logic [7:0] in8_data, out8_data;
    logic [2:0] in8_shift;
    logic [1:0] in8_mode;
    logic       in8_pad;

    logic       in6_valid, in6_ready, out6_valid, out6_ready;
    logic [5:0] in6_data, out6_data;
    logic [2:0] in6_shift;
    logic [1:0] in6_mode;
    logic       in6_pad;

    int n_vec = 0;
    int n_err = 0;
    int n_out = 0;
    int n0    = 0;
    int exp_q[$];
    bit stalled   = 1'b0;
    int held      = 0;
    bit saw_block = 1'b0;
    bit rnd_done  = 1'b0;

    always #5 clock = ~clock;

    barrel_shifter_pipelined #(.WIDTH(8), .SHIFT_WIDTH(3), .STAGES(3)) dut8 (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (in8_valid),
        .in_ready  (in8_ready),
        .in_data   (in8_data),
        .in_shift  (in8_shift),
        .in_mode   (in8_mode),
        .in_pad    (in8_pad),
        .out_valid (out8_valid),
        .out_ready (out8_ready),
        .out_data  (out8_data)
    );

    barrel_shifter_pipelined #(.WIDTH(6), .SHIFT_WIDTH(3), .STAGES(1)) dut6 (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (in6_valid),
        .in_ready  (in6_ready),
        .in_data   (in6_data),
        .in_shift  (in6_shift),
        .in_mode   (in6_mode),
        .in_pad    (in6_pad),
        .out_valid (out6_valid),
        .out_ready (out6_ready),
        .out_data  (out6_data)
    );

    // Reference: each result bit taken directly from its source bit position.
    function automatic int model(input int data, input int sh, input int mode, input int pad, input int w);
        int res;
        int sign;
        int src;
        int b;
        res  = 0;
        sign = (data >> (w - 1)) & 1;
        for (int j = 0; j < w; j++) begin
            case (mode)
                0: begin src = j + sh; b = (src < w) ? ((data >> src) & 1) : pad;  end
                1: begin src = j - sh; b = (src >= 0) ? ((data >> src) & 1) : pad; end
                2: begin src = j + sh; b = (src < w) ? ((data >> src) & 1) : sign; end
                default: begin src = (j + sh) % w; b = (data >> src) & 1; end
            endcase
            res = res | (b << j);
        end
        return res;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process for the 8-bit instance, sampled mid-cycle.
    always @(negedge clock) begin
        if (!resetn) begin
            exp_q.delete();
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall_valid", int'(out8_valid), 1);
                chk("stall_hold", int'(out8_data), held);
            end
            if (out8_valid) begin
                if (exp_q.size() == 0) begin
                    chk("no_stale_out", int'(out8_valid), 0);
                end else begin
                    chk("data", int'(out8_data), exp_q[0]);
                    if (out8_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end else begin
                chk("idle_zero", int'(out8_data), 0);
            end
            stalled = out8_valid && !out8_ready;
            held    = int'(out8_data);
            if (in8_valid && in8_ready)
                exp_q.push_back(model(int'(in8_data), int'(in8_shift), int'(in8_mode), int'(in8_pad), 8));
            if (in8_valid && !in8_ready)
                saw_block = 1'b1;
        end
    end

    task automatic send8(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m, input logic p);
        int t;
        t = 0;
        in8_valid = 1'b1;
        in8_data  = d;
        in8_shift = s;
        in8_mode  = m;
        in8_pad   = p;
        forever begin
            @(negedge clock);
            if (in8_ready) break;
            t++;
            if (t > 1000) begin
                chk("send_accept_timeout", int'(in8_ready), 1);
                break;
            end
        end
        @(posedge clock);
        #1;
        in8_valid = 1'b0;
    endtask

    task automatic run_one8(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m,
                            input logic p, input int exp);
        int k;
        k = 0;
        send8(d, s, m, p);
        while (!out8_valid && k < 20) begin
            @(posedge clock);
            #1;
            k++;
        end
        chk("latency", k + 1, 3);
        chk("data_literal", int'(out8_data), exp);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        in8_valid = 0; in8_data = 0; in8_shift = 0; in8_mode = 0; in8_pad = 0; out8_ready = 1;
        in6_valid = 0; in6_data = 0; in6_shift = 0; in6_mode = 0; in6_pad = 0; out6_ready = 1;
        #22 resetn = 1'b1;
        @(posedge clock);
        #1;
        chk("reset_in_ready8",  int'(in8_ready), 1);
        chk("reset_out_valid8", int'(out8_valid), 0);
        chk("reset_out_data8",  int'(out8_data), 0);
        chk("reset_in_ready6",  int'(in6_ready), 1);
        chk("reset_out_valid6", int'(out6_valid), 0);
        chk("reset_out_data6",  int'(out6_data), 0);

        // Pin the reference model to hand-computed results
        chk("model_lsr",    model('hB4, 3, 0, 0, 8), 'h16);
        chk("model_asr",    model('h96, 2, 2, 0, 8), 'hE5);
        chk("model_lsl",    model('h96, 4, 1, 1, 8), 'h6F);
        chk("model_ror",    model('h96, 3, 3, 0, 8), 'hD2);
        chk("model_w6_lsr", model('h2D, 7, 0, 1, 6), 'h3F);
        chk("model_w6_ror", model('h2D, 7, 3, 0, 6), 'h36);

        // Directed single beats, no backpressure
        run_one8(8'hB4, 3'd3, 2'b00, 1'b0, 'h16);
        run_one8(8'h96, 3'd2, 2'b10, 1'b0, 'hE5);
        run_one8(8'h96, 3'd4, 2'b01, 1'b1, 'h6F);
        run_one8(8'h96, 3'd3, 2'b11, 1'b0, 'hD2);
        run_one8(8'h5A, 3'd0, 2'b10, 1'b1, 'h5A);
        run_one8(8'h5A, 3'd7, 2'b10, 1'b1, 'h00);
        run_one8(8'h5A, 3'd7, 2'b11, 1'b0, 'hB4);
        run_one8(8'h81, 3'd0, 2'b01, 1'b1, 'h81);

        // Backpressure: 6 back-to-back beats with a 4-cycle output stall mid-stream
        saw_block = 1'b0;
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send8(8'(8'h13 * (i + 1)), 3'(i + 1), 2'(i), 1'(i));
            end
            begin
                repeat (3) @(posedge clock);
                #1 out8_ready = 1'b0;
                repeat (4) @(posedge clock);
                #1 out8_ready = 1'b1;
            end
        join
        repeat (10) @(posedge clock);
        #1;
        chk("bp_in_ready_dropped", int'(saw_block), 1);
        chk("bp_delivered", n_out - n0, 6);
        chk("bp_queue_empty", exp_q.size(), 0);

        // Reset with 3 beats in flight
        out8_ready = 1'b0;
        send8(8'hF0, 3'd1, 2'b00, 1'b0);
        send8(8'h0F, 3'd2, 2'b01, 1'b1);
        send8(8'hAA, 3'd5, 2'b10, 1'b0);
        chk("full_out_valid", int'(out8_valid), 1);
        chk("full_in_ready", int'(in8_ready), 0);
        #1 resetn = 1'b0;
        #1;
        chk("rst_async_valid", int'(out8_valid), 0);
        chk("rst_async_data", int'(out8_data), 0);
        @(posedge clock);
        #2 resetn = 1'b1;
        out8_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("rst_release_in_ready", int'(in8_ready), 1);
        repeat (6) @(posedge clock);
        #1;
        chk("rst_no_stale", int'(out8_valid), 0);

        // Non-power-of-two width, single stage
        in6_valid = 1'b1; in6_data = 6'h2D; in6_shift = 3'd7; in6_mode = 2'b00; in6_pad = 1'b1;
        #1 chk("w6_in_ready", int'(in6_ready), 1);
        @(posedge clock);
        #1;
        in6_mode = 2'b11; in6_pad = 1'b0;
        chk("w6_lsr_valid", int'(out6_valid), 1);
        chk("w6_lsr_data", int'(out6_data), 'h3F);
        @(posedge clock);
        #1;
        in6_valid = 1'b0;
        chk("w6_ror_valid", int'(out6_valid), 1);
        chk("w6_ror_data", int'(out6_data), 'h36);
        @(posedge clock);
        #1;
        chk("w6_idle_valid", int'(out6_valid), 0);
        chk("w6_idle_data", int'(out6_data), 0);

        // Random traffic, all modes, random gaps and output stalls
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    if ($urandom_range(3) == 0) begin
                        @(posedge clock);
                        #1;
                    end
                    send8(8'($urandom_range(255)), 3'($urandom_range(7)),
                          2'($urandom_range(3)), 1'($urandom_range(1)));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clock);
                    #1 out8_ready = ($urandom_range(3) != 0);
                end
                out8_ready = 1'b1;
            end
        join
        repeat (10) @(posedge clock);
        #1;
        chk("rnd_queue_empty", exp_q.size(), 0);

        // Sustained throughput with out_ready held high
        saw_block = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++)
                    send8(8'($urandom_range(255)), 3'($urandom_range(7)),
                          2'($urandom_range(3)), 1'($urandom_range(1)));
            end
            begin
                repeat (8) @(posedge clock);
                #2 n0 = n_out;
                repeat (25) @(posedge clock);
                #2 chk("throughput", n_out - n0, 25);
            end
        join
        repeat (10) @(posedge clock);
        #1;
        chk("tp_no_in_stall", int'(saw_block), 0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
